// File: rtl/slow_bus_bridge_pkg.sv
// Shared types and constants for the slow-rate CPU to memory bridge.
// Holds the FSM state enum, abort read value and default widths.
package bus_bridge_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 8;
  localparam int CNT_W       = 8;

  localparam logic [63:0] ERR_RDATA = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } bridge_state_t;

endpackage

// File: rtl/slow_bus_bridge_if.sv
// Memory-side request/acknowledge bus of the slow bus bridge.
// master: bridge drives req/we/addr/wdata; slave: memory drives ack/rdata.
import bus_bridge_pkg::*;

interface slow_bus_bridge_if #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/slow_bus_bridge_req_timeout_counter.sv
// Counts request cycles; expired is high in the last allowed REQ cycle.
// Ports: clk, nrst, clr (restart at 0), inc (advance), expired.
import bus_bridge_pkg::*;

module req_timeout_counter #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic nrst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/slow_bus_bridge.sv
// Turns a slow_pulse CPU cycle into one mem_req/mem_ack transaction.
// Ports: clk, nrst, CPU side (pulse/addr/wdata/rw/rdata/ready/err), bus.
import bus_bridge_pkg::*;

module slow_bus_bridge #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              slow_pulse,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rw,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_err,
  slow_bus_bridge_if.master bus
);

  bridge_state_t state_q, state_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic capture;
  logic take_ack;
  logic abort;
  logic cnt_clr;
  logic cnt_inc;
  logic expired;

  req_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack is checked before expiry so a late ack still wins.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    take_ack = 1'b0;
    abort    = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (slow_pulse) begin
          capture = 1'b1;
          cnt_clr = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          take_ack = 1'b1;
          state_d  = DONE;
        end else if (expired) begin
          abort   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (capture) begin
        we_q    <= ~cpu_rw;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (take_ack && !we_q) begin
        rdata_q <= bus.mem_rdata;
      end
      if (abort) begin
        err_q <= 1'b1;
        if (!we_q) begin
          rdata_q <= DATA_W'(ERR_RDATA);
        end
      end
    end
  end

  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign cpu_ready = (state_q != REQ);
  assign cpu_rdata = rdata_q;
  assign bus_err   = err_q;

endmodule
